// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: issues in-order imem requests from the PC register's value,
// tracks in-flight PCs and buffers returned words for decode; redirects flush and drop stale data.
`timescale 1ns/1ps
module if_fetch_unit #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        pc_en,
    output logic [31:0] npc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned OccW = CntW + 2;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 2");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("RESET_PC must be word aligned");
    end

    logic [31:0]     pc_fifo_q   [DEPTH];
    logic [31:0]     buf_pc_q    [DEPTH];
    logic [31:0]     buf_instr_q [DEPTH];
    logic [PtrW-1:0] pcf_wptr_q, pcf_rptr_q, buf_wptr_q, buf_rptr_q;
    logic [CntW-1:0] infl_cnt_q, infl_cnt_d;
    logic [CntW-1:0] buf_cnt_q, buf_cnt_d;
    logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
    logic [OccW-1:0] occupancy;
    logic            credit, fire, resp_take, resp_drop, id_pop;

    always_comb begin
        occupancy      = OccW'(infl_cnt_q) + OccW'(buf_cnt_q) + OccW'(drop_cnt_q);
        credit         = occupancy < OccW'(DEPTH);
        imem_req_valid = !rst && credit && !redirect_valid;
        imem_addr      = pc;
        fire           = imem_req_valid && imem_req_ready;

        pc_en = 1'b0;
        npc   = pc;
        if (!rst && redirect_valid) begin
            pc_en = 1'b1;
            npc   = redirect_target;
        end else if (fire) begin
            pc_en = 1'b1;
            npc   = pc + 32'd4;
        end

        // An orphan response (nothing in flight, nothing to drop) is ignored.
        resp_drop = imem_resp_valid && (drop_cnt_q != '0);
        resp_take = imem_resp_valid && (drop_cnt_q == '0) && (infl_cnt_q != '0);

        id_valid = buf_cnt_q != '0;
        id_pop   = id_valid && id_ready;
        id_pc    = buf_pc_q[buf_rptr_q];
        id_instr = buf_instr_q[buf_rptr_q];

        infl_cnt_d = infl_cnt_q + CntW'(fire) - CntW'(resp_take);
        buf_cnt_d  = buf_cnt_q + CntW'(resp_take) - CntW'(id_pop);
        drop_cnt_d = drop_cnt_q - CntW'(resp_drop);
        if (redirect_valid) begin
            // Everything still in flight becomes stale; the word arriving now is already gone.
            infl_cnt_d = '0;
            buf_cnt_d  = '0;
            drop_cnt_d = drop_cnt_q + infl_cnt_q - CntW'(resp_drop || resp_take);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            infl_cnt_q <= '0;
            buf_cnt_q  <= '0;
            drop_cnt_q <= '0;
            pcf_wptr_q <= '0;
            pcf_rptr_q <= '0;
            buf_wptr_q <= '0;
            buf_rptr_q <= '0;
        end else begin
            infl_cnt_q <= infl_cnt_d;
            buf_cnt_q  <= buf_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            if (redirect_valid) begin
                pcf_wptr_q <= '0;
                pcf_rptr_q <= '0;
                buf_wptr_q <= '0;
                buf_rptr_q <= '0;
            end else begin
                if (fire)      pcf_wptr_q <= pcf_wptr_q + 1'b1;
                if (resp_take) pcf_rptr_q <= pcf_rptr_q + 1'b1;
                if (resp_take) buf_wptr_q <= buf_wptr_q + 1'b1;
                if (id_pop)    buf_rptr_q <= buf_rptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fire) begin
            pc_fifo_q[pcf_wptr_q] <= pc;
        end
        if (resp_take && !redirect_valid) begin
            buf_pc_q[buf_wptr_q]    <= pc_fifo_q[pcf_rptr_q];
            buf_instr_q[buf_wptr_q] <= imem_resp_data;
        end
    end

    resp_orphan_a: assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid |-> (infl_cnt_q != '0 || drop_cnt_q != '0));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: models the PC register and an in-order imem, scoreboards decode output.
`timescale 1ns/1ps
module tb_if_fetch_unit;
    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_r = RESET_PC;
    logic        pc_en;
    logic [31:0] npc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    if_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc_r),
        .pc_en           (pc_en),
        .npc             (npc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_pc           (id_pc),
        .id_instr        (id_instr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int          due;
        logic [31:0] addr;
    } resp_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    resp_t       mem_q[$];
    int          cyc = 0;
    int          lat = 1;
    int          last_due = 0;
    int          hs_cnt = 0;
    int          fire_cnt = 0;
    logic        want_first = 1'b0;
    logic [31:0] first_hs_pc = 32'hDEAD_BEEF;
    logic        found;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One clock: sample at posedge+2, update models, return at next posedge+1.
    task automatic step();
        logic        f, hs, rd;
        logic [31:0] nxt, e;
        int          due;
        resp_t       r;
        #1;
        f   = imem_req_valid && imem_req_ready;
        hs  = id_valid && id_ready;
        rd  = redirect_valid;
        nxt = pc_r;
        if (rd) begin
            check_eq("no_req_on_redirect", 32'(imem_req_valid), 32'd0);
            nxt = redirect_target;
        end else if (f) begin
            nxt = pc_r + 32'd4;
        end
        check_eq("pc_en", 32'(pc_en), 32'(rd || f));
        check_eq("npc", npc, nxt);
        if (f) check_eq("imem_addr", imem_addr, pc_r);
        if (hs) begin
            hs_cnt++;
            if (want_first) begin
                first_hs_pc = id_pc;
                want_first  = 1'b0;
            end
            check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("id_pc", id_pc, e);
                check_eq("id_instr", id_instr, mem_word(e));
            end
        end
        if (rd) exp_q.delete();
        if (f) begin
            exp_q.push_back(pc_r);
            fire_cnt++;
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            mem_q.push_back('{due: due, addr: pc_r});
            last_due = due;
        end
        @(posedge clk);
        #1;
        cyc++;
        pc_r            = rst ? RESET_PC : nxt;
        redirect_valid  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (mem_q.size() != 0 && mem_q[0].due == cyc) begin
            r               = mem_q.pop_front();
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(r.addr);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        #1;
        check_eq("rst_id_valid", 32'(id_valid), 32'd0);
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_pc_en", 32'(pc_en), 32'd0);
        exp_q.delete();
        mem_q.delete();
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        pc_r            = RESET_PC;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        last_due = cyc;
        #1;
        check_eq("post_rst_id_valid", 32'(id_valid), 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        imem_req_ready = 1'b0;
        id_ready       = 1'b1;
        while ((exp_q.size() != 0 || mem_q.size() != 0) && n < 50) begin
            step();
            n++;
        end
        check_eq("drain_left", 32'(exp_q.size() + mem_q.size()), 32'd0);
    endtask

    task automatic start_first();
        want_first  = 1'b1;
        first_hs_pc = 32'hDEAD_BEEF;
        hs_cnt      = 0;
        fire_cnt    = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        // Free run, 1-cycle memory.
        reset_dut();
        check_eq("reset_pc", pc_r, RESET_PC);
        lat = 1; id_ready = 1'b1; imem_req_ready = 1'b1;
        start_first();
        repeat (30) step();
        check_eq("t1_first_pc", first_hs_pc, RESET_PC);
        check_eq("t1_progress", 32'(hs_cnt >= 10), 32'd1);
        drain();

        // Decode stalled: exactly DEPTH requests, PC holds.
        reset_dut();
        lat = 1; id_ready = 1'b0; imem_req_ready = 1'b1;
        start_first();
        repeat (10) step();
        check_eq("t2_fires", 32'(fire_cnt), 32'(DEPTH));
        check_eq("t2_pc_hold", pc_r, 32'd8);
        id_ready = 1'b1;
        for (int i = 0; i < 20 && hs_cnt < 3; i++) step();
        check_eq("t2_first_pc", first_hs_pc, 32'd0);
        check_eq("t2_delivered", 32'(hs_cnt >= 3), 32'd1);
        drain();

        // Toggling request ready, 3-cycle latency.
        reset_dut();
        lat = 3; id_ready = 1'b1;
        start_first();
        for (int i = 0; i < 40; i++) begin
            imem_req_ready = (i % 2) == 0;
            step();
        end
        drain();
        check_eq("t3_no_gaps", 32'(hs_cnt), 32'(fire_cnt));
        check_eq("t3_progress", 32'(fire_cnt >= 8), 32'd1);

        // Redirect with two requests in flight.
        reset_dut();
        lat = 3; id_ready = 1'b0; imem_req_ready = 1'b1;
        start_first();
        step();
        step();
        check_eq("t4_inflight", 32'(fire_cnt), 32'd2);
        redirect_valid = 1'b1; redirect_target = 32'h100;
        step();
        id_ready = 1'b1;
        start_first();
        repeat (14) step();
        check_eq("t4_first_pc", first_hs_pc, 32'h100);
        check_eq("t4_delivered", 32'(hs_cnt >= 2), 32'd1);

        // Redirect to the top of memory: PC wraps to 0.
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        step();
        start_first();
        repeat (14) step();
        check_eq("wrap_first_pc", first_hs_pc, 32'hFFFF_FFFC);
        check_eq("wrap_delivered", 32'(hs_cnt >= 2), 32'd1);
        drain();

        // Redirect coinciding with a response and a decode handshake.
        reset_dut();
        lat = 1; id_ready = 1'b1; imem_req_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (imem_resp_valid && id_valid) begin
                found = 1'b1;
                redirect_valid = 1'b1; redirect_target = 32'h200;
            end
            step();
        end
        check_eq("t5_found", 32'(found), 32'd1);
        start_first();
        repeat (14) step();
        check_eq("t5_first_pc", first_hs_pc, 32'h200);
        check_eq("t5_delivered", 32'(hs_cnt >= 3), 32'd1);

        // Asynchronous reset with a full buffer.
        reset_dut();
        lat = 1; id_ready = 1'b0; imem_req_ready = 1'b1;
        repeat (6) step();
        #1;
        check_eq("t6_full", 32'(id_valid), 32'd1);
        reset_dut();
        lat = 1; id_ready = 1'b1; imem_req_ready = 1'b1;
        start_first();
        repeat (12) step();
        check_eq("t6_first_pc", first_hs_pc, RESET_PC);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
